trace_capture_buffer: RTL and testbench

Synthesizable, parametrised capture buffer for pipeline debug. It records register writeback events (PC, destination register, write data) into an on-chip circular buffer. Capture runs either until the buffer is full or until a trigger fires plus a post-trigger window. The records are then drained over a valid/ready stream. It sits beside the core's writeback stage and replaces per-cycle register-file dumping with selective, trigger-based capture.

---
 rtl/trace_capture_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Trigger-based capture of writeback events into a circular buffer,
// drained oldest-first over a valid/ready stream.
module trace_capture_buffer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_arm,
    input  logic                     i_mode,
    input  logic                     i_trig,
    input  logic                     i_cap_valid,
    input  logic [DATA_W-1:0]        i_cap_pc,
    input  logic [ADDR_W-1:0]        i_cap_rd,
    input  logic [DATA_W-1:0]        i_cap_wdata,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [DATA_W-1:0]        o_rd_pc,
    output logic [ADDR_W-1:0]        o_rd_rd,
    output logic [DATA_W-1:0]        o_rd_wdata,
    output logic                     o_rd_last,
    output logic [1:0]               o_state,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 2 * DATA_W + ADDR_W;
    localparam int PST_W = $clog2(POST_TRIG + 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [PST_W-1:0]   post_cnt_q, post_cnt_d;
    logic               overflow_q, overflow_d;
    logic               prime_q, prime_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic               done_q, done_d;
    logic [REC_W-1:0]   rd_rec_q;

    logic               cap_we;
    logic               full;
    logic               rd_load;
    logic [PTR_W-1:0]   rd_addr;

    logic [REC_W-1:0]   mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        post_cnt_d  = post_cnt_q;
        overflow_d  = overflow_q;
        prime_d     = 1'b0;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        done_d      = 1'b0;
        rd_addr     = rd_ptr_q;
        rd_load     = (state_q == S_DRAIN);
        cap_we      = i_cap_valid && ((state_q == S_CAPTURE) || (state_q == S_POST));
        full        = (count_q == CNT_W'(DEPTH));

        // A write into a full buffer displaces the oldest record (mode 1 only;
        // mode 0 leaves CAPTURE on the write that fills it).
        if (cap_we) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end else if (mode_q) begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_arm) begin
                    state_d    = S_CAPTURE;
                    mode_d     = i_mode;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    post_cnt_d = '0;
                    overflow_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (!mode_q) begin
                    if ((cap_we && (count_q == CNT_W'(DEPTH - 1))) || i_trig) begin
                        state_d = S_DRAIN;
                    end
                end else if (i_trig) begin
                    if (POST_TRIG == 0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d    = S_POST;
                        post_cnt_d = PST_W'(POST_TRIG);
                    end
                end
            end
            S_POST: begin
                if (cap_we) begin
                    post_cnt_d = post_cnt_q - PST_W'(1);
                    if (post_cnt_q == PST_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // First DRAIN cycle primes the read register at the oldest record.
                if (prime_q) begin
                    rd_valid_d = (remaining_q != '0);
                    rd_last_d  = (remaining_q == CNT_W'(1));
                    if (remaining_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (rd_valid_q && i_rd_ready) begin
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                    rd_addr     = rd_ptr_d;
                    remaining_d = remaining_q - CNT_W'(1);
                    rd_valid_d  = (remaining_q > CNT_W'(1));
                    rd_last_d   = (remaining_q == CNT_W'(2));
                    if (rd_last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // When full the write pointer sits on the oldest record.
        if ((state_q != S_DRAIN) && (state_d == S_DRAIN)) begin
            rd_ptr_d    = (count_d == CNT_W'(DEPTH)) ? wr_ptr_d : '0;
            remaining_d = count_d;
            prime_d     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            post_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            prime_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            post_cnt_q  <= post_cnt_d;
            overflow_q  <= overflow_d;
            prime_q     <= prime_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (cap_we) begin
            mem[wr_ptr_q] <= {i_cap_pc, i_cap_rd, i_cap_wdata};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_rec_q <= '0;
        end else if (rd_load) begin
            rd_rec_q <= mem[rd_addr];
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_last  = rd_last_q;
    assign o_rd_pc    = rd_rec_q[REC_W-1 -: DATA_W];
    assign o_rd_rd    = rd_rec_q[DATA_W +: ADDR_W];
    assign o_rd_wdata = rd_rec_q[DATA_W-1:0];
    assign o_state    = state_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomized bench for trace_capture_buffer; expected drains come from a
// queue model of the capture rules (oldest-first, keep newest DEPTH records).
module tb_trace_capture_buffer;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    localparam int P_IDLE  = 0;
    localparam int P_CAP   = 1;
    localparam int P_POST  = 2;
    localparam int P_DRAIN = 3;

    typedef struct {
        logic [DATA_W-1:0] pc;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] wd;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              i_arm, i_mode, i_trig, i_cap_valid, i_rd_ready;
    logic [DATA_W-1:0] i_cap_pc, i_cap_wdata;
    logic [ADDR_W-1:0] i_cap_rd;
    logic              o_rd_valid, o_rd_last, o_overflow, o_done;
    logic [DATA_W-1:0] o_rd_pc, o_rd_wdata;
    logic [ADDR_W-1:0] o_rd_rd;
    logic [1:0]        o_state;
    logic [CNT_W-1:0]  o_count;

    logic              arm2, mode2, trig2, valid2, ready2;
    logic              rd_valid2, rd_last2, overflow2, done2;
    logic [DATA_W-1:0] rd_pc2, rd_wdata2;
    logic [ADDR_W-1:0] rd_rd2;
    logic [1:0]        state2;
    logic [CNT_W-1:0]  count2;

    trace_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .i_clk(clk), .i_rst(rst), .i_arm(i_arm), .i_mode(i_mode), .i_trig(i_trig),
        .i_cap_valid(i_cap_valid), .i_cap_pc(i_cap_pc), .i_cap_rd(i_cap_rd), .i_cap_wdata(i_cap_wdata),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_pc(o_rd_pc), .o_rd_rd(o_rd_rd),
        .o_rd_wdata(o_rd_wdata), .o_rd_last(o_rd_last), .o_state(o_state), .o_count(o_count),
        .o_overflow(o_overflow), .o_done(o_done)
    );

    trace_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .POST_TRIG(0)) dut_nopost (
        .i_clk(clk), .i_rst(rst), .i_arm(arm2), .i_mode(mode2), .i_trig(trig2),
        .i_cap_valid(valid2), .i_cap_pc(i_cap_pc), .i_cap_rd(i_cap_rd), .i_cap_wdata(i_cap_wdata),
        .o_rd_valid(rd_valid2), .i_rd_ready(ready2), .o_rd_pc(rd_pc2), .o_rd_rd(rd_rd2),
        .o_rd_wdata(rd_wdata2), .o_rd_last(rd_last2), .o_state(state2), .o_count(count2),
        .o_overflow(overflow2), .o_done(done2)
    );

    int checks = 0;
    int errors = 0;

    rec_t mq[$];
    bit   m_ovf;
    bit   m_mode;
    int   m_phase;
    int   m_post;

    function automatic void model_step(input bit v, input bit t, input rec_t r);
        if (m_phase == P_CAP || m_phase == P_POST) begin
            if (v) begin
                mq.push_back(r);
                if (mq.size() > DEPTH) begin
                    void'(mq.pop_front());
                    m_ovf = 1'b1;
                end
            end
            if (m_phase == P_CAP) begin
                if (!m_mode) begin
                    if (mq.size() == DEPTH || t) m_phase = P_DRAIN;
                end else if (t) begin
                    if (POST_TRIG == 0) m_phase = P_DRAIN;
                    else begin
                        m_phase = P_POST;
                        m_post  = POST_TRIG;
                    end
                end
            end else if (v) begin
                m_post--;
                if (m_post == 0) m_phase = P_DRAIN;
            end
        end
    endfunction

    task automatic do_arm(input bit mode);
        @(posedge clk); #1;
        i_arm = 1'b1; i_mode = mode; i_cap_valid = 1'b0; i_trig = 1'b0;
        mq.delete();
        m_ovf = 1'b0; m_mode = mode; m_phase = P_CAP; m_post = 0;
    endtask

    // trig_at >= 0: trigger together with record number trig_at;
    // trig_at < 0: trigger alone in the first capture cycle.
    task automatic run_capture(input string name, input int trig_at, input bit pattern,
                               input bit gaps, input bit arm_noise, input int max_rec);
        int   k = 0;
        int   cyc = 0;
        bit   v, t;
        rec_t r;
        while (m_phase != P_DRAIN && k < max_rec && cyc < 400) begin
            @(posedge clk); #1;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (trig_at < 0 && cyc == 0) v = 1'b0;
            t = (trig_at < 0) ? (cyc == 0) : (v && k == trig_at);
            if (pattern) begin
                r.pc = DATA_W'(32'h100 + 4 * k);
                r.rd = ADDR_W'(k);
                r.wd = DATA_W'(k * 3);
            end else begin
                r.pc = $urandom;
                r.rd = ADDR_W'($urandom);
                r.wd = $urandom;
            end
            i_cap_valid = v; i_trig = t;
            i_cap_pc = r.pc; i_cap_rd = r.rd; i_cap_wdata = r.wd;
            i_arm = arm_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (arm_noise) i_mode = 1'($urandom_range(0, 1));
            model_step(v, t, r);
            if (v) k++;
            cyc++;
        end
        if (m_phase != P_DRAIN && k < max_rec) begin
            checks++; errors++;
            $display("FAIL %s capture_timeout: got no DRAIN after %0d cycles, required DRAIN", name, cyc);
        end
    endtask

    // ready_mode: 0 always ready, 1 toggling 1,0,1,0, 2 random.
    task automatic run_drain(input string name, input int ready_mode, input bit noise);
        int n = mq.size();
        int hs = 0, dones = 0, first = -1, last_hs = -1;
        bit rdy, stalled = 1'b0;
        logic [DATA_W-1:0] spc, swd;
        logic [ADDR_W-1:0] srd;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_rd_ready = rdy;
            if (noise) begin
                i_cap_valid = 1'($urandom_range(0, 1)); i_trig = 1'($urandom_range(0, 1));
                i_arm = 1'($urandom_range(0, 1)); i_cap_pc = $urandom; i_cap_wdata = $urandom;
                i_cap_rd = ADDR_W'($urandom);
            end else begin
                i_cap_valid = 1'b0; i_trig = 1'b0; i_arm = 1'b0;
            end
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (o_state !== 2'd3 || o_rd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s drain_entry: got state=%0d valid=%b, required state=3 valid=0", name, o_state, o_rd_valid);
                end
            end
            if (o_done) dones++;
            if (stalled && !o_rd_valid) begin
                checks++; errors++;
                $display("FAIL %s valid_dropped: got valid=0 while stalled, required 1", name);
            end
            if (o_rd_valid) begin
                if (first < 0) first = c;
                if (stalled) begin
                    checks++;
                    if (o_rd_pc !== spc || o_rd_rd !== srd || o_rd_wdata !== swd) begin
                        errors++;
                        $display("FAIL %s stall_stable: got pc=%h rd=%0d wd=%h, required pc=%h rd=%0d wd=%h",
                                 name, o_rd_pc, o_rd_rd, o_rd_wdata, spc, srd, swd);
                    end
                end
                checks++;
                if (hs >= n) begin
                    errors++;
                    $display("FAIL %s extra_record: got record %0d, required only %0d", name, hs, n);
                end else begin
                    if (o_rd_pc !== mq[hs].pc || o_rd_rd !== mq[hs].rd || o_rd_wdata !== mq[hs].wd) begin
                        errors++;
                        $display("FAIL %s record[%0d]: got pc=%h rd=%0d wd=%h, required pc=%h rd=%0d wd=%h",
                                 name, hs, o_rd_pc, o_rd_rd, o_rd_wdata, mq[hs].pc, mq[hs].rd, mq[hs].wd);
                    end
                    checks++;
                    if (o_rd_last !== (hs == n - 1)) begin
                        errors++;
                        $display("FAIL %s last[%0d]: got %b, required %b", name, hs, o_rd_last, (hs == n - 1));
                    end
                end
                if (rdy) begin
                    hs++; last_hs = c; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; spc = o_rd_pc; srd = o_rd_rd; swd = o_rd_wdata;
                end
            end else begin
                stalled = 1'b0;
            end
            if (dones > 0) break;
        end
        i_arm = 1'b0; i_cap_valid = 1'b0; i_trig = 1'b0;
        checks++;
        if (hs !== n) begin
            errors++;
            $display("FAIL %s handshakes: got %0d, required %0d", name, hs, n);
        end
        checks++;
        if (dones !== 1 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL %s done: got pulses=%0d state=%0d, required pulses=1 state=0", name, dones, o_state);
        end
        checks++;
        if (o_count !== CNT_W'(n) || o_overflow !== m_ovf) begin
            errors++;
            $display("FAIL %s count_ovf: got count=%0d ovf=%b, required count=%0d ovf=%b", name, o_count, o_overflow, n, m_ovf);
        end
        if (n > 0) begin
            checks++;
            if (first !== 1) begin
                errors++;
                $display("FAIL %s first_valid: got cycle %0d, required cycle 1", name, first);
            end
            checks++;
            if ((ready_mode == 0 && last_hs - first + 1 != n) || (ready_mode == 1 && last_hs - first + 1 > 2 * n)) begin
                errors++;
                $display("FAIL %s throughput: got %0d cycles for %0d records", name, last_hs - first + 1, n);
            end
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_rd_valid !== 1'b0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b valid=%b state=%0d, required 0 0 0", name, o_done, o_rd_valid, o_state);
        end
        m_phase = P_IDLE;
        $display("txn %s: mode=%0d records=%0d handshakes=%0d ovf=%b", name, m_mode, n, hs, o_overflow);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_state !== 2'd0 || o_count !== '0 || o_rd_valid !== 1'b0 || o_done !== 1'b0 || o_overflow !== 1'b0
            || o_rd_last !== 1'b0 || o_rd_pc !== '0 || o_rd_rd !== '0 || o_rd_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d count=%0d valid=%b done=%b ovf=%b, required all 0",
                     o_state, o_count, o_rd_valid, o_done, o_overflow);
        end
        rst = 1'b0;
        $display("txn reset: state=%0d count=%0d", o_state, o_count);
    endtask

    task automatic test_mode0_full;
        do_arm(1'b0);
        run_capture("mode0_full", 1000, 1'b1, 1'b0, 1'b0, 1000);
        run_drain("mode0_full", 0, 1'b0);
    endtask

    task automatic test_mode1_wrap;
        do_arm(1'b1);
        run_capture("mode1_wrap", 19, 1'b1, 1'b0, 1'b0, 1000);
        run_drain("mode1_wrap", 0, 1'b0);
    endtask

    task automatic test_mode1_short;
        do_arm(1'b1);
        run_capture("mode1_short", 2, 1'b1, 1'b0, 1'b0, 1000);
        run_drain("mode1_short", 0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_arm(1'b0);
        run_capture("backpressure", 1000, 1'b1, 1'b0, 1'b0, 1000);
        run_drain("backpressure", 1, 1'b0);
    endtask

    task automatic test_reset_mid;
        do_arm(1'b1);
        run_capture("reset_mid", 7, 1'b0, 1'b0, 1'b0, 10);
        @(posedge clk); #1;
        i_cap_valid = 1'b0; i_trig = 1'b0;
        checks++;
        if (o_state !== 2'd2) begin
            errors++;
            $display("FAIL reset_mid pre_state: got %0d, required 2", o_state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_state !== 2'd0 || o_count !== '0 || o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: got state=%0d count=%0d valid=%b, required 0 0 0", o_state, o_count, o_rd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_phase = P_IDLE;
        $display("txn reset_mid: state=%0d count=%0d", o_state, o_count);
        do_arm(1'b0);
        run_capture("after_reset", 1000, 1'b0, 1'b0, 1'b0, 1000);
        run_drain("after_reset", 2, 1'b0);
    endtask

    task automatic test_ignore_inputs;
        do_arm(1'b1);
        run_capture("ignore_inputs", 11, 1'b0, 1'b1, 1'b1, 1000);
        run_drain("ignore_inputs", 2, 1'b1);
    endtask

    task automatic test_zero_capture;
        int d2 = 0, v2 = 0;
        do_arm(1'b0);
        run_capture("zero_mode0", -1, 1'b0, 1'b0, 1'b0, 1000);
        run_drain("zero_mode0", 0, 1'b0);
        ready2 = 1'b1;
        @(posedge clk); #1; arm2 = 1'b1; mode2 = 1'b1;
        @(posedge clk); #1; arm2 = 1'b0; trig2 = 1'b1;
        @(posedge clk); #1; trig2 = 1'b0;
        @(negedge clk);
        checks++;
        if (state2 !== 2'd3) begin
            errors++;
            $display("FAIL zero_nopost state: got %0d, required 3", state2);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done2) d2++;
            if (rd_valid2) v2++;
        end
        checks++;
        if (d2 !== 1 || v2 !== 0 || state2 !== 2'd0 || count2 !== '0) begin
            errors++;
            $display("FAIL zero_nopost: got done=%0d valid=%0d state=%0d count=%0d, required 1 0 0 0", d2, v2, state2, count2);
        end
        $display("txn zero_nopost: done_pulses=%0d records=%0d", d2, v2);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            do_arm(1'($urandom_range(0, 1)));
            run_capture("random", int'($urandom_range(0, 30)), 1'b0, 1'b1, 1'b0, 1000);
            run_drain("random", 2, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_arm = 1'b0; i_mode = 1'b0; i_trig = 1'b0; i_cap_valid = 1'b0; i_rd_ready = 1'b0;
        i_cap_pc = '0; i_cap_rd = '0; i_cap_wdata = '0;
        arm2 = 1'b0; mode2 = 1'b0; trig2 = 1'b0; valid2 = 1'b0; ready2 = 1'b0;
        m_phase = P_IDLE; m_ovf = 1'b0; m_mode = 1'b0; m_post = 0;
        test_reset();
        test_mode0_full();
        test_mode1_wrap();
        test_mode1_short();
        test_backpressure();
        test_reset_mid();
        test_ignore_inputs();
        test_zero_capture();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
